// File: rtl/i2c_slave_rx.sv
// Write-only I2C target receiver: oversamples SCL/SDA, detects START/STOP,
// matches a 7-bit address, ACKs open-drain style and strobes out each data byte.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter bit         RW_IGNORE   = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda,
  output logic       i2c_sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_rw,
  output logic       addr_match,
  output logic       busy,
  output logic       stop_seen,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACK_A  = 3'd2,
    S_DATA   = 3'd3,
    S_ACK_D  = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic       byte_done, byte_done_n;
  logic       oe_n, rx_valid_n, rx_rw_n, match_n, busy_n, stop_n;
  logic [7:0] rx_data_n;

  // Synchronisers preset to 1 so reset looks like an idle bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd7;
      shift      <= 8'h00;
      byte_done  <= 1'b0;
      i2c_sda_oe <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_rw      <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
      stop_seen  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      byte_done  <= byte_done_n;
      i2c_sda_oe <= oe_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      rx_rw      <= rx_rw_n;
      addr_match <= match_n;
      busy       <= busy_n;
      stop_seen  <= stop_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    byte_done_n = byte_done;
    oe_n        = i2c_sda_oe;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    rx_rw_n     = rx_rw;
    match_n     = addr_match;
    busy_n      = busy;
    stop_n      = 1'b0;
    if (stop_det) begin
      state_n     = S_IDLE;
      oe_n        = 1'b0;
      busy_n      = 1'b0;
      match_n     = 1'b0;
      stop_n      = 1'b1;
      byte_done_n = 1'b0;
    end else if (start_det) begin
      state_n     = S_ADDR;
      bit_cnt_n   = 3'd7;
      shift_n     = 8'h00;
      oe_n        = 1'b0;
      match_n     = 1'b0;
      busy_n      = 1'b1;
      byte_done_n = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_DATA: begin
          // byte_done holds off further shifting until the ACK slot begins
          if (scl_rise && !byte_done) begin
            shift_n = {shift[6:0], sda_s};
            if (bit_cnt == 3'd0) begin
              byte_done_n = 1'b1;
              if (state == S_DATA) begin
                rx_data_n  = {shift[6:0], sda_s};
                rx_valid_n = 1'b1;
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            if (state == S_ADDR) begin
              rx_rw_n = shift[0];
              if (shift[7:1] == SLAVE_ADDR && (RW_IGNORE || !shift[0])) begin
                oe_n    = 1'b1;
                state_n = S_ACK_A;
              end else begin
                state_n = S_IGNORE;
              end
            end else begin
              oe_n    = 1'b1;
              state_n = S_ACK_D;
            end
          end
        end
        S_ACK_A: begin
          if (scl_fall) begin
            oe_n      = 1'b0;
            match_n   = 1'b1;
            bit_cnt_n = 3'd7;
            state_n   = S_DATA;
          end
        end
        S_ACK_D: begin
          if (scl_fall) begin
            oe_n      = 1'b0;
            bit_cnt_n = 3'd7;
            state_n   = S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
